// File: rtl/nv_nvdla_sdp_rdma_cq_param.sv
// nv_nvdla_sdp_rdma_cq_param
// Parametrised context queue between the SDP RDMA ingress and egress stages.
// Flop-array storage with a registered output stage. The output register counts
// as an occupied entry. Supports a runtime write limit, synchronous flush,
// occupancy and almost-full status.
// Optional feature macro: NVDLA_SDP_CQ_STALL_PERF_EN adds cq_stall_cnt, a
// saturating count of cycles where ingress is valid but not ready.
//
// Handshake: a word moves on an interface in any cycle where valid and ready
// are both high at the clock edge. Once cq2eg_pvld is high, cq2eg_pvld and
// cq2eg_pd hold until the word is taken. ig2cq_prdy does not depend on
// ig2cq_pvld in the same cycle.
module nv_nvdla_sdp_rdma_cq_param #(
    parameter  int DATA_W    = 16,
    parameter  int DEPTH     = 160,
    parameter  int AF_MARGIN = 4,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic              nvdla_core_clk_mgated,
    input  logic              nvdla_core_rstn,
    input  logic              cq_flush,
    input  logic [CW-1:0]     cq_wr_limit,
    input  logic              ig2cq_pvld,
    output logic              ig2cq_prdy,
    input  logic [DATA_W-1:0] ig2cq_pd,
    output logic              cq2eg_pvld,
    input  logic              cq2eg_prdy,
    output logic [DATA_W-1:0] cq2eg_pd,
    output logic [CW-1:0]     cq_count,
    output logic              cq_almost_full
`ifdef NVDLA_SDP_CQ_STALL_PERF_EN
    ,
    output logic [31:0]       cq_stall_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Threshold at or below zero means almost-full is permanently asserted.
    localparam int          AF_TH     = DEPTH - AF_MARGIN;
    localparam logic        AF_ALWAYS = (AF_TH <= 0);
    localparam int          AF_TH_C   = AF_ALWAYS ? 0 : AF_TH;
    localparam logic [CW:0] AF_TH_U   = AF_TH_C[CW:0];
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_busy;
    logic              r_af;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_out_pd;

    logic              w_push;
    logic              w_pop;
    logic              w_arr_empty;
    logic              w_load;
    logic              w_bypass;
    logic              w_arr_wr;
    logic              w_arr_rd;
    logic [CW-1:0]     w_count_next;
    logic              w_busy_next;
    logic              w_af_next;

    // Flush suppresses both handshakes so nothing in its cycle alters state.
    assign w_push       = ig2cq_pvld & ~r_busy & ~cq_flush;
    assign w_pop        = r_out_vld & cq2eg_prdy & ~cq_flush;
    // Array holds every occupied entry except the one in the output register.
    assign w_arr_empty  = (r_count == CW'(r_out_vld));
    assign w_load       = ~r_out_vld | w_pop;
    assign w_bypass     = w_load & w_arr_empty & w_push;
    assign w_arr_wr     = w_push & ~w_bypass;
    assign w_arr_rd     = w_load & ~w_arr_empty & ~cq_flush;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_busy_next  = (w_count_next == CW'(DEPTH)) |
                          ((cq_wr_limit != '0) & (w_count_next >= cq_wr_limit));
    assign w_af_next    = ({1'b0, w_count_next} >= AF_TH_U);

    assign ig2cq_prdy     = ~r_busy;
    assign cq2eg_pvld     = r_out_vld;
    assign cq2eg_pd       = r_out_pd;
    assign cq_count       = r_count;
    assign cq_almost_full = r_af;

    // Storage array write; contents need no reset.
    always_ff @(posedge nvdla_core_clk_mgated) begin
        if (w_arr_wr) begin
            r_mem[r_wr_ptr] <= ig2cq_pd;
        end
    end

    // Pointers, occupancy, status flags and the output register.
    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_af      <= 1'b0;
            r_out_vld <= 1'b0;
            r_out_pd  <= '0;
        end else if (cq_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_af      <= AF_ALWAYS;
            r_out_vld <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_busy  <= w_busy_next;
            r_af    <= w_af_next;
            if (w_arr_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_arr_rd) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            // Refill the output register from the array, or straight from
            // ingress when the array is empty, whenever it is free or popped.
            if (w_load) begin
                if (!w_arr_empty) begin
                    r_out_vld <= 1'b1;
                    r_out_pd  <= r_mem[r_rd_ptr];
                end else if (w_push) begin
                    r_out_vld <= 1'b1;
                    r_out_pd  <= ig2cq_pd;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end
        end
    end

`ifdef NVDLA_SDP_CQ_STALL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall      = ig2cq_pvld & r_busy;
    assign cq_stall_cnt = r_stall_cnt;

    // Saturating count of ingress stall cycles, cleared by flush.
    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall_cnt <= '0;
        end else if (cq_flush) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_cq_param.sv
// Testbench for nv_nvdla_sdp_rdma_cq_param: instance A uses default sizing
// (DEPTH=160, AF_MARGIN=4), instance B uses DEPTH=5, AF_MARGIN=1 for wrap stress.
module tb_nv_nvdla_sdp_rdma_cq_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // ---------------- instance A signals ----------------
  logic        a_flush, a_pvld, a_prdy, a_evld, a_eprdy, a_af;
  logic [7:0]  a_limit, a_count;
  logic [15:0] a_pd, a_epd;
  logic [31:0] a_stall;

  // ---------------- instance B signals ----------------
  logic        b_flush, b_pvld, b_prdy, b_evld, b_eprdy, b_af;
  logic [2:0]  b_limit, b_count;
  logic [15:0] b_pd, b_epd;
  logic [31:0] b_stall;

  nv_nvdla_sdp_rdma_cq_param u_dut_a (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .cq_flush              (a_flush),
    .cq_wr_limit           (a_limit),
    .ig2cq_pvld            (a_pvld),
    .ig2cq_prdy            (a_prdy),
    .ig2cq_pd              (a_pd),
    .cq2eg_pvld            (a_evld),
    .cq2eg_prdy            (a_eprdy),
    .cq2eg_pd              (a_epd),
    .cq_count              (a_count),
    .cq_almost_full        (a_af)
`ifdef NVDLA_SDP_CQ_STALL_PERF_EN
    ,
    .cq_stall_cnt          (a_stall)
`endif
  );

  nv_nvdla_sdp_rdma_cq_param #(.DATA_W(16), .DEPTH(5), .AF_MARGIN(1)) u_dut_b (
    .nvdla_core_clk_mgated (clk),
    .nvdla_core_rstn       (rstn),
    .cq_flush              (b_flush),
    .cq_wr_limit           (b_limit),
    .ig2cq_pvld            (b_pvld),
    .ig2cq_prdy            (b_prdy),
    .ig2cq_pd              (b_pd),
    .cq2eg_pvld            (b_evld),
    .cq2eg_prdy            (b_eprdy),
    .cq2eg_pd              (b_epd),
    .cq_count              (b_count),
    .cq_almost_full        (b_af)
`ifdef NVDLA_SDP_CQ_STALL_PERF_EN
    ,
    .cq_stall_cnt          (b_stall)
`endif
  );

`ifndef NVDLA_SDP_CQ_STALL_PERF_EN
  assign a_stall = 32'd0;
  assign b_stall = 32'd0;
`endif

  // ---------------- scoreboard / reference model ----------------
  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  logic        ma_busy, ma_af, mb_busy, mb_af;
  logic [31:0] ma_stall;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q_a.delete();
    exp_q_b.delete();
    ma_busy  = 1'b0;
    ma_af    = 1'b0;
    mb_busy  = 1'b0;
    mb_af    = 1'b0;
    ma_stall = 32'd0;
  endtask

  // One clock of instance A: predict, advance, compare against the model.
  task automatic step_a();
    logic mp, mo;
    mp = a_pvld && !ma_busy && !a_flush;
    mo = (exp_q_a.size() > 0) && a_eprdy && !a_flush;
    if (a_flush) ma_stall = 32'd0;
    else if (a_pvld && ma_busy && ma_stall != 32'hFFFF_FFFF) ma_stall = ma_stall + 32'd1;
    @(posedge clk); #1;
    if (a_flush) begin
      exp_q_a.delete();
      ma_busy = 1'b0;
      ma_af   = 1'b0;
    end else begin
      if (mo) void'(exp_q_a.pop_front());
      if (mp) exp_q_a.push_back(a_pd);
      ma_busy = (exp_q_a.size() == 160) || (a_limit != 8'd0 && exp_q_a.size() >= int'(a_limit));
      ma_af   = (exp_q_a.size() >= 156);
    end
    check("a_prdy", 32'(a_prdy), 32'(!ma_busy));
    check("a_count", 32'(a_count), 32'(exp_q_a.size()));
    check("a_af", 32'(a_af), 32'(ma_af));
    check("a_evld", 32'(a_evld), 32'(exp_q_a.size() > 0));
    if (exp_q_a.size() > 0) check("a_order", 32'(a_epd), 32'(exp_q_a[0]));
`ifdef NVDLA_SDP_CQ_STALL_PERF_EN
    check("a_stall", a_stall, ma_stall);
`endif
  endtask

  // One clock of instance B (DEPTH=5, almost-full at 4).
  task automatic step_b();
    logic mp, mo;
    mp = b_pvld && !mb_busy && !b_flush;
    mo = (exp_q_b.size() > 0) && b_eprdy && !b_flush;
    @(posedge clk); #1;
    if (b_flush) begin
      exp_q_b.delete();
      mb_busy = 1'b0;
      mb_af   = 1'b0;
    end else begin
      if (mo) void'(exp_q_b.pop_front());
      if (mp) exp_q_b.push_back(b_pd);
      mb_busy = (exp_q_b.size() == 5);
      mb_af   = (exp_q_b.size() >= 4);
    end
    check("b_prdy", 32'(b_prdy), 32'(!mb_busy));
    check("b_count", 32'(b_count), 32'(exp_q_b.size()));
    check("b_af", 32'(b_af), 32'(mb_af));
    check("b_evld", 32'(b_evld), 32'(exp_q_b.size() > 0));
    if (exp_q_b.size() > 0) check("b_order", 32'(b_epd), 32'(exp_q_b[0]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    a_flush = 0; a_pvld = 0; a_eprdy = 0; a_pd = '0; a_limit = 8'd0;
    b_flush = 0; b_pvld = 0; b_eprdy = 0; b_pd = '0; b_limit = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdy", 32'(a_prdy), 32'd1);
    check("rst_evld", 32'(a_evld), 32'd0);
    check("rst_pd", 32'(a_epd), 32'd0);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_af", 32'(a_af), 32'd0);
    check("rst_stall", a_stall, 32'd0);
    rstn = 1'b1;

    // Test 1: fill to DEPTH without pops, then drain in order.
    for (int i = 0; i < 160; i++) begin
      a_pvld = 1'b1; a_pd = 16'(i);
      step_a();
      if (i == 154) check("t1_af_at_155", 32'(a_af), 32'd0);
      if (i == 155) check("t1_af_at_156", 32'(a_af), 32'd1);
      if (i == 158) check("t1_prdy_at_159", 32'(a_prdy), 32'd1);
    end
    check("t1_full_count", 32'(a_count), 32'd160);
    check("t1_full_prdy", 32'(a_prdy), 32'd0);
    a_pd = 16'hFFFF;
    step_a();
    check("t1_no_overflow", 32'(a_count), 32'd160);
    a_pvld = 1'b0; a_eprdy = 1'b1;
    for (int i = 0; i < 160; i++) begin
      check("t1_drain_vld", 32'(a_evld), 32'd1);
      check("t1_drain_pd", 32'(a_epd), 32'(i));
      step_a();
    end
    check("t1_empty_count", 32'(a_count), 32'd0);
    check("t1_empty_vld", 32'(a_evld), 32'd0);

    // Test 2: single push latency and output stability under backpressure.
    a_eprdy = 1'b0; a_pvld = 1'b1; a_pd = 16'hA5A5;
    step_a();
    a_pvld = 1'b0; a_pd = 16'h0000;
    check("t2_vld", 32'(a_evld), 32'd1);
    check("t2_pd", 32'(a_epd), 32'hA5A5);
    for (int i = 0; i < 5; i++) begin
      step_a();
      check("t2_hold_pd", 32'(a_epd), 32'hA5A5);
      check("t2_hold_vld", 32'(a_evld), 32'd1);
    end
    a_eprdy = 1'b1;
    step_a();
    check("t2_popped", 32'(a_evld), 32'd0);

    // Test 3: runtime write limit.
    a_eprdy = 1'b0; a_limit = 8'd8; a_pvld = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_pd = 16'(16'h0100 + i);
      step_a();
    end
    check("t3_limit_count", 32'(a_count), 32'd8);
    check("t3_limit_prdy", 32'(a_prdy), 32'd0);
    a_limit = 8'd0; a_pvld = 1'b0;
    step_a();
    check("t3_unlimit_prdy", 32'(a_prdy), 32'd1);
    a_pvld = 1'b1;
    for (int i = 0; i < 155; i++) begin
      a_pd = 16'(16'h0200 + i);
      step_a();
    end
    check("t3_full_count", 32'(a_count), 32'd160);
    a_pvld = 1'b0; a_eprdy = 1'b1;
    for (int i = 0; i < 160; i++) step_a();
    check("t3_drained", 32'(a_count), 32'd0);

    // Test 5: flush with simultaneous push and pop.
    a_eprdy = 1'b0; a_pvld = 1'b1;
    for (int i = 0; i < 37; i++) begin
      a_pd = 16'(16'h0300 + i);
      step_a();
    end
    check("t5_pre_count", 32'(a_count), 32'd37);
    a_pd = 16'hDEAD; a_eprdy = 1'b1; a_flush = 1'b1;
    step_a();
    check("t5_count", 32'(a_count), 32'd0);
    check("t5_vld", 32'(a_evld), 32'd0);
    check("t5_prdy", 32'(a_prdy), 32'd1);
    a_flush = 1'b0; a_pvld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_a();
      check("t5_no_dead", 32'(a_evld), 32'd0);
    end
    a_flush = 1'b1; a_pvld = 1'b1; a_pd = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step_a();
      check("t5_held_prdy", 32'(a_prdy), 32'd1);
      check("t5_held_count", 32'(a_count), 32'd0);
    end
    a_flush = 1'b0; a_pd = 16'h1234; a_eprdy = 1'b0;
    step_a();
    a_pvld = 1'b0;
    check("t5_after_pd", 32'(a_epd), 32'h1234);
    a_eprdy = 1'b1;
    step_a();
    a_eprdy = 1'b0;

`ifdef NVDLA_SDP_CQ_STALL_PERF_EN
    // Test 6: stall counter with limit 2.
    a_limit = 8'd2; a_pvld = 1'b1; a_pd = 16'h0600;
    for (int i = 0; i < 10; i++) step_a();
    check("t6_stall", a_stall, 32'd8);
    a_pvld = 1'b0; a_flush = 1'b1;
    step_a();
    check("t6_stall_flush", a_stall, 32'd0);
    a_flush = 1'b0; a_limit = 8'd0;
`endif

    // Test 4: wrap stress on DEPTH=5 with random handshakes and rare flush.
    for (int i = 0; i < 1000; i++) begin
      b_pvld  = ($urandom_range(0, 3) != 0);
      b_eprdy = ($urandom_range(0, 2) != 0);
      b_pd    = 16'($urandom_range(0, 65535));
      b_flush = ($urandom_range(0, 99) == 0);
      step_b();
    end
    b_pvld = 1'b0; b_eprdy = 1'b0; b_flush = 1'b0;

    // Asynchronous reset in mid-operation.
    a_pvld = 1'b1; a_pd = 16'h0777;
    for (int i = 0; i < 3; i++) step_a();
    a_pvld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(a_count), 32'd0);
    check("arst_vld", 32'(a_evld), 32'd0);
    check("arst_prdy", 32'(a_prdy), 32'd1);
    check("arst_pd", 32'(a_epd), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    step_a();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_sdp_rdma_cq_param.md
Name: nv_nvdla_sdp_rdma_cq_param

Overview:
Parametrised context queue for the SDP read-DMA engines (BRDMA/NRDMA/ERDMA). It sits between the DMA request ingress stage and the read-return egress stage, and carries per-request context words. It extends the fixed 160x16 queue with the following additions:
- configurable width and depth;
- a runtime write limit driven from a port rather than a plusarg;
- synchronous flush;
- occupancy and almost-full status outputs.
Storage is an internal flop array with a registered output stage.

Parameters:
DATA_W, 16, context word width in bits.
DEPTH, 160, number of entries; 2..256; need not be a power of 2.
AF_MARGIN, 4, almost-full asserts when occupancy >= DEPTH-AF_MARGIN.
CW, $clog2(DEPTH+1), occupancy/limit width (derived, not overridden).

Ports:
nvdla_core_clk_mgated  in  1  clock.
nvdla_core_rstn  in  1  reset.
cq_flush  in  1  synchronous flush, one-cycle pulse or level.
cq_wr_limit  in  CW  runtime write limit; 0 = use DEPTH.
ig2cq_pvld  in  1  ingress valid.
ig2cq_prdy  out  1  ingress ready.
ig2cq_pd  in  DATA_W  ingress context word.
cq2eg_pvld  out  1  egress valid.
cq2eg_prdy  in  1  egress ready.
cq2eg_pd  out  DATA_W  egress context word.
cq_count  out  CW  registered occupancy.
cq_almost_full  out  1  registered almost-full.

Behaviour:
- Clock and reset: clock nvdla_core_clk_mgated; reset nvdla_core_rstn, asynchronous, active-low.
- Reset values: ig2cq_prdy=1, cq2eg_pvld=0, cq2eg_pd=0, cq_count=0, cq_almost_full=0. Pointers are 0 at reset.
- Push and pop:
  - push = ig2cq_pvld & ig2cq_prdy.
  - pop = cq2eg_pvld & cq2eg_prdy.
- Occupancy: count = entries accepted and not yet popped, including the output register.
  - count_next = count + push - pop.
  - Push and pop in the same cycle leave count unchanged.
- Busy (registered):
  - busy_next = (count_next == DEPTH) | (cq_wr_limit != 0 & count_next >= cq_wr_limit).
  - ig2cq_prdy = !busy.
  - No push is ever accepted at count == DEPTH; overflow is impossible by construction.
- Write limit: changes to cq_wr_limit take effect on the next busy evaluation.
  - A limit below the current count deasserts prdy the next cycle.
  - Stored data is never dropped.
- Pointers: write and read pointers wrap DEPTH-1 -> 0 (explicit compare, not modulo 2^n).
- Latency: a push into an empty queue in cycle N makes cq2eg_pvld=1 with that word in cycle N+1.
- Throughput: sustained 1 push and 1 pop per cycle.
  - A pop with count >= 2 presents the next entry in the following cycle with no bubble.
- Output stability: cq2eg_pd and cq2eg_pvld hold stable while cq2eg_pvld & !cq2eg_prdy.
- Count of 1 with simultaneous push and pop: cq2eg_pvld stays 1 and the new word appears next cycle.
- Order: strict FIFO; no reordering.
- Almost-full: cq_almost_full <= (count_next >= DEPTH-AF_MARGIN).
  - If AF_MARGIN >= DEPTH, cq_almost_full is constant 1 after reset.
- Flush: highest priority; takes effect on the next edge.
  - Pointers, count, busy and almost_full clear; cq2eg_pvld=0.
  - A push or pop presented in the flush cycle is discarded/ignored and does not alter state.
  - ig2cq_prdy=1 in the cycle after flush, unless the flush is held.
  - While cq_flush is held, prdy stays 1 but pushes are discarded.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Array contents are don't-care.
- Array writes: no enable beyond push; array contents carry no reset requirement.

Optional Feature:
Macro NVDLA_SDP_CQ_STALL_PERF_EN.
- With the macro defined:
  - Adds output port cq_stall_cnt (out, 32 bits): a saturating counter of cycles with ig2cq_pvld & !ig2cq_prdy.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset and by cq_flush.
  - Registered, with the same reset domain as the rest of the block.
- Without the macro: the port and counter are absent; no other behaviour changes.

Test Plan:
1. DEPTH=160, limit=0: push 160 words 0..159 back-to-back with egress prdy=0 -> prdy drops the cycle after push #160, count=160, almost_full from count 156. Then drain with prdy=1 -> words 0..159 in order, one per cycle, count returns to 0.
2. Empty queue, single push of 16'hA5A5 at cycle N -> cq2eg_pvld=1 and pd=16'hA5A5 at N+1. Egress prdy=0 for 5 cycles -> pd stable for those cycles; pop on the 6th cycle -> pvld=0 next cycle.
3. cq_wr_limit=8, continuous pushes, no pops -> exactly 8 accepted, prdy=0. Set limit=0 -> prdy=1 next cycle, accepts up to 160.
4. Wrap stress: DEPTH=5 (non-power-of-2), random pvld/prdy for 1000 cycles -> scoreboard order matches, count equals the model every cycle, pointers wrap 4 -> 0 with no loss.
5. Flush with count=37 and simultaneous push and pop -> next cycle count=0, cq2eg_pvld=0, prdy=1. The pushed word never appears at egress.
6. With NVDLA_SDP_CQ_STALL_PERF_EN defined, limit=2, pvld held high for 10 cycles with no pops -> cq_stall_cnt=8 (10 cycles minus 2 accepted). A flush resets it to 0.
